// File: rtl/spi_flash_pkg.sv
// Shared definitions for the SPI NOR flash erase controller: opcodes, erase mode
// encoding and the controller state type.
package spi_flash_pkg;

    localparam logic [7:0] OP_WREN = 8'h06;
    localparam logic [7:0] OP_RDSR = 8'h05;
    localparam logic [7:0] OP_BE   = 8'hC7;
    localparam logic [7:0] OP_SE   = 8'hD8;
    localparam logic [7:0] OP_SSE  = 8'h20;

    localparam logic [7:0] STATUS_WIP_MASK = 8'h01;

    typedef enum logic [1:0] {
        MODE_BULK      = 2'd0,
        MODE_SECTOR    = 2'd1,
        MODE_SUBSECTOR = 2'd2,
        MODE_ILLEGAL   = 2'd3
    } erase_mode_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WREN,
        ST_GAP1,
        ST_CMD,
        ST_GAP2,
        ST_POLL,
        ST_DONE
    } erase_state_t;

    function automatic logic [7:0] erase_opcode(input erase_mode_t mode);
        case (mode)
            MODE_SECTOR:    return OP_SE;
            MODE_SUBSECTOR: return OP_SSE;
            default:        return OP_BE;
        endcase
    endfunction

endpackage

// File: rtl/spi_byte_xfer.sv
// Full-duplex SPI mode-0 byte shifter. A start request made while a byte is in
// flight is queued and begins seamlessly at that byte's last falling edge.
module spi_byte_xfer #(
    parameter int CLK_DIV = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] tx_byte,
    input  logic       miso,
    output logic [7:0] rx_byte,
    output logic       byte_done,
    output logic       sclk,
    output logic       mosi,
    output logic       active
);

    localparam int DIV_W = $clog2(CLK_DIV + 1);

    logic [DIV_W-1:0] div_cnt;
    logic [3:0]       half;
    logic             pre;
    logic [7:0]       shreg;
    logic             nxt_valid;
    logic [7:0]       nxt_byte;
    logic             half_end;
    logic [7:0]       load_byte;

    assign half_end  = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign load_byte = nxt_valid ? nxt_byte : tx_byte;

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt   <= '0;
            half      <= '0;
            pre       <= 1'b0;
            shreg     <= '0;
            nxt_valid <= 1'b0;
            nxt_byte  <= '0;
            rx_byte   <= '0;
            byte_done <= 1'b0;
            sclk      <= 1'b0;
            mosi      <= 1'b0;
            active    <= 1'b0;
        end else begin
            byte_done <= 1'b0;
            if (!active) begin
                if (start) begin
                    active  <= 1'b1;
                    pre     <= 1'b1;
                    shreg   <= tx_byte;
                    mosi    <= tx_byte[7];
                    half    <= '0;
                    div_cnt <= '0;
                end
            end else begin
                if (start) begin
                    nxt_valid <= 1'b1;
                    nxt_byte  <= tx_byte;
                end
                // One setup cycle with CS low and the first bit already on MOSI.
                if (pre) begin
                    pre <= 1'b0;
                end else if (!half_end) begin
                    div_cnt <= div_cnt + 1'b1;
                end else begin
                    div_cnt <= '0;
                    half    <= half + 4'd1;
                    if (!half[0]) begin
                        sclk    <= 1'b1;
                        rx_byte <= {rx_byte[6:0], miso};
                        if (half == 4'd14) begin
                            byte_done <= 1'b1;
                        end
                    end else begin
                        sclk <= 1'b0;
                        if (half != 4'd15) begin
                            shreg <= {shreg[6:0], 1'b0};
                            mosi  <= shreg[6];
                        end else if (nxt_valid || start) begin
                            shreg     <= load_byte;
                            mosi      <= load_byte[7];
                            nxt_valid <= 1'b0;
                        end else begin
                            active <= 1'b0;
                            mosi   <= 1'b0;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: rtl/spi_flash_erase.sv
// SPI NOR flash erase controller: write enable, erase command with optional
// address, then status polling until WIP clears or the poll budget runs out.
//
// state | meaning
// IDLE  | waiting for erase_req; latches mode and address
// WREN  | CS low, shifting write-enable opcode
// GAP1  | CS high between WREN and the erase command
// CMD   | CS low, shifting erase opcode and address bytes
// GAP2  | CS high between erase command and status polling
// POLL  | CS low, RDSR then continuous status reads
// DONE  | CS high, emit done/err next cycle
module spi_flash_erase
    import spi_flash_pkg::*;
#(
    parameter int CLK_DIV    = 2,
    parameter int ADDR_BYTES = 3,
    parameter int CS_GAP     = 4,
    parameter int POLL_MAX   = 65535
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        erase_req,
    input  logic [1:0]  erase_mode,
    input  logic [31:0] erase_addr,
    output logic        erase_ack,
    output logic        busy,
    output logic        done,
    output logic        err,
    input  logic        spi_miso,
    output logic        spi_sclk,
    output logic        spi_cs,
    output logic        spi_mosi
);

    localparam int GAP_W      = $clog2(CS_GAP + 1);
    localparam int POLL_W     = $clog2(POLL_MAX + 1);
    localparam int ADDR_SHIFT = 8 * (4 - ADDR_BYTES);

    erase_state_t     state, state_n;
    erase_mode_t      mode_r, mode_n;
    logic [31:0]      addr_sh, addr_n;
    logic [2:0]       addr_left, addr_left_n;
    logic [GAP_W-1:0] gap_cnt, gap_n;
    logic [POLL_W-1:0] poll_left, poll_n;
    logic             cmd_sent, cmd_sent_n;
    logic             err_flag, err_flag_n;
    logic             cs_n, ack_n, busy_n, done_n, err_n;

    logic             xfer_start;
    logic [7:0]       xfer_tx;
    logic [7:0]       rx_byte;
    logic             byte_done;
    logic             xfer_active;
    logic             wip;

    assign wip = |(rx_byte & STATUS_WIP_MASK);

    spi_byte_xfer #(
        .CLK_DIV(CLK_DIV)
    ) u_xfer (
        .clk      (sys_clk),
        .rst      (sys_rst),
        .start    (xfer_start),
        .tx_byte  (xfer_tx),
        .miso     (spi_miso),
        .rx_byte  (rx_byte),
        .byte_done(byte_done),
        .sclk     (spi_sclk),
        .mosi     (spi_mosi),
        .active   (xfer_active)
    );

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state     <= ST_IDLE;
            mode_r    <= MODE_BULK;
            addr_sh   <= '0;
            addr_left <= '0;
            gap_cnt   <= '0;
            poll_left <= '0;
            cmd_sent  <= 1'b0;
            err_flag  <= 1'b0;
            spi_cs    <= 1'b1;
            erase_ack <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_n;
            mode_r    <= mode_n;
            addr_sh   <= addr_n;
            addr_left <= addr_left_n;
            gap_cnt   <= gap_n;
            poll_left <= poll_n;
            cmd_sent  <= cmd_sent_n;
            err_flag  <= err_flag_n;
            spi_cs    <= cs_n;
            erase_ack <= ack_n;
            busy      <= busy_n;
            done      <= done_n;
            err       <= err_n;
        end
    end

    always_comb begin
        state_n     = state;
        mode_n      = mode_r;
        addr_n      = addr_sh;
        addr_left_n = addr_left;
        gap_n       = gap_cnt;
        poll_n      = poll_left;
        cmd_sent_n  = cmd_sent;
        err_flag_n  = err_flag;
        cs_n        = spi_cs;
        ack_n       = 1'b0;
        busy_n      = busy;
        done_n      = 1'b0;
        err_n       = 1'b0;
        xfer_start  = 1'b0;
        xfer_tx     = 8'h00;

        case (state)
            ST_IDLE: begin
                busy_n = 1'b0;
                // busy is still high during the done cycle; requests there are dropped
                if (erase_req && !busy) begin
                    ack_n       = 1'b1;
                    busy_n      = 1'b1;
                    mode_n      = erase_mode_t'(erase_mode);
                    addr_n      = erase_addr << ADDR_SHIFT;
                    addr_left_n = (erase_mode_t'(erase_mode) == MODE_BULK) ? 3'd0 : 3'(ADDR_BYTES);
                    if (erase_mode_t'(erase_mode) == MODE_ILLEGAL) begin
                        err_flag_n = 1'b1;
                        state_n    = ST_DONE;
                    end else begin
                        err_flag_n = 1'b0;
                        cs_n       = 1'b0;
                        xfer_start = 1'b1;
                        xfer_tx    = OP_WREN;
                        state_n    = ST_WREN;
                    end
                end
            end
            ST_WREN: begin
                if (!xfer_active) begin
                    cs_n    = 1'b1;
                    gap_n   = GAP_W'(CS_GAP - 1);
                    state_n = ST_GAP1;
                end
            end
            ST_GAP1: begin
                if (gap_cnt == '0) begin
                    cs_n       = 1'b0;
                    xfer_start = 1'b1;
                    xfer_tx    = erase_opcode(mode_r);
                    state_n    = ST_CMD;
                end else begin
                    gap_n = gap_cnt - 1'b1;
                end
            end
            ST_CMD: begin
                if (byte_done && addr_left != 3'd0) begin
                    xfer_start  = 1'b1;
                    xfer_tx     = addr_sh[31:24];
                    addr_n      = {addr_sh[23:0], 8'h00};
                    addr_left_n = addr_left - 3'd1;
                end else if (!xfer_active) begin
                    cs_n    = 1'b1;
                    gap_n   = GAP_W'(CS_GAP - 1);
                    state_n = ST_GAP2;
                end
            end
            ST_GAP2: begin
                if (gap_cnt == '0) begin
                    cs_n       = 1'b0;
                    xfer_start = 1'b1;
                    xfer_tx    = OP_RDSR;
                    cmd_sent_n = 1'b0;
                    state_n    = ST_POLL;
                end else begin
                    gap_n = gap_cnt - 1'b1;
                end
            end
            ST_POLL: begin
                if (byte_done) begin
                    if (!cmd_sent) begin
                        cmd_sent_n = 1'b1;
                        poll_n     = POLL_W'(POLL_MAX);
                        xfer_start = 1'b1;
                    end else if (!wip) begin
                        err_flag_n = 1'b0;
                    end else if (poll_left == POLL_W'(1)) begin
                        err_flag_n = 1'b1;
                    end else begin
                        poll_n     = poll_left - 1'b1;
                        xfer_start = 1'b1;
                    end
                end else if (!xfer_active) begin
                    cs_n    = 1'b1;
                    state_n = ST_DONE;
                end
            end
            ST_DONE: begin
                done_n  = 1'b1;
                err_n   = err_flag;
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

endmodule

// File: doc/spi_flash_erase.md
# spi_flash_erase

Parametrised SPI NOR flash erase controller covering bulk (chip), sector and subsector erase. It issues Write Enable, then the erase command with an optional address, then polls the status register until the Write-In-Progress bit clears or a timeout expires. It sits between system control logic and the flash pins, and replaces the fixed bulk-erase-only control/driver pair.

## Interface
Parameters:
- `CLK_DIV`, default 2: SCLK half-period in `sys_clk` cycles (≥1); SCLK = sys_clk/(2·CLK_DIV).
- `ADDR_BYTES`, default 3: address bytes sent for sector/subsector erase (3 or 4).
- `CS_GAP`, default 4: `sys_clk` cycles CS stays high between transactions (≥1).
- `POLL_MAX`, default 65535: max status bytes read before timeout (≥1).

Ports:
- `sys_clk` in 1: system clock (50 MHz nominal).
- `sys_rst` in 1: reset; **one clock; reset is synchronous and active-high**.
- `erase_req` in 1: start request, sampled only in IDLE.
- `erase_mode` in 2: 0 = bulk (0xC7), 1 = sector (0xD8), 2 = subsector (0x20), 3 = illegal.
- `erase_addr` in 32: erase address; low `8·ADDR_BYTES` bits used, MSB first.
- `erase_ack` out 1: one-cycle pulse when a request is accepted.
- `busy` out 1: high from acceptance through the `done` cycle.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: valid with `done`; 1 = illegal mode or poll timeout.
- `spi_miso` in 1: flash serial data out.
- `spi_sclk` out 1: SPI clock, mode 0.
- `spi_cs` out 1: chip select, active low.
- `spi_mosi` out 1: serial data to flash.

## Operation
- Reset values: `spi_cs`=1, `spi_sclk`=0, `spi_mosi`=0, `erase_ack`=`busy`=`done`=`err`=0, FSM in IDLE. Reset asserted mid-operation aborts at once and drives these values on the next edge.
- FSM states: IDLE → WREN → GAP1 → CMD → GAP2 → POLL → DONE → IDLE.
- IDLE: on `erase_req`=1, latch mode and address, pulse `erase_ack`, raise `busy`. Mode 3 goes straight to DONE with `err`=1, and CS never toggles.
- WREN: CS low, send 0x06, CS high.
- GAP1/GAP2: CS high for exactly `CS_GAP` cycles.
- CMD: CS low, send opcode. Sector/subsector modes then send `ADDR_BYTES` address bytes, MSB byte first. CS high.
- POLL: CS low, send 0x05, then read status bytes continuously with MOSI held 0. After each byte, if bit0 (WIP)=0, raise CS and go to DONE with `err`=0. If `POLL_MAX` bytes have been read with WIP still 1, raise CS and go to DONE with `err`=1.
- DONE: pulse `done` for 1 cycle, then drop `busy`.
- `erase_req` while busy is ignored and not queued.

## Timing
- SPI mode 0: SCLK idles low. MOSI changes on the falling edge (first bit set up when CS falls). MISO is sampled on the rising edge. Bits go MSB first.
- One byte = 8 SCLK periods = 16·CLK_DIV cycles.
- CS falls 1 cycle before byte 0 begins. CS rises 1 cycle after the last falling edge.
- `erase_ack` follows the `erase_req` sample by 1 cycle, and CS falls on that same cycle.
- Status decision is made in the cycle after the 8th rising edge of each status byte. When WIP=0, no further SCLK edges follow.
- Latency for bulk erase with immediate WIP=0: WREN (1+16·CLK_DIV+1) + CS_GAP + CMD (1+16·CLK_DIV+1) + CS_GAP + POLL (1+32·CLK_DIV+1) + 1 cycles to `done`.

## Structure
- Shared package `spi_flash_pkg`: opcode constants (WREN 0x06, RDSR 0x05, BE 0xC7, SE 0xD8, SSE 0x20), mode encoding, FSM state type.
- Sub-module `spi_byte_xfer`: full-duplex byte shifter with `CLK_DIV` divider.
  - Inputs: `start`, `tx_byte`.
  - Outputs: `rx_byte`, `byte_done` (1-cycle), `sclk`, `mosi`.
  - The top FSM owns CS, byte counting and poll counting.

## Test plan
- Bulk erase, CLK_DIV=2, flash model returns status 0x00 → MOSI bytes 06 | C7 | 05. CS high between each for exactly 4 cycles. `done`=1, `err`=0.
- Sector erase, addr 0x12_3456, ADDR_BYTES=3, status 0x03,0x03,0x00 → MOSI bytes D8 12 34 56. Three status bytes are read in one CS window, then `done`, `err`=0.
- Subsector erase, ADDR_BYTES=4, addr 0xAB12_3400 → MOSI bytes 20 AB 12 34 00.
- Mode 3 → `erase_ack`, then `done`+`err`=1 within 3 cycles. CS stays 1 throughout.
- POLL_MAX=4, status stuck at 0x01 → exactly 4 status bytes read, then `err`=1. Also assert `erase_req` while busy → no second ack.
- Assert `sys_rst` in the middle of the CMD byte → next cycle CS=1, SCLK=0, MOSI=0, `busy`=0. A new request then runs cleanly.
